// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide sequencer.
//   - FSM state encoding
//   - operation codes driven on the op port
//   - default operand width and iteration counter width
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned MULDIV_ITER  = MULDIV_WIDTH;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITER);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MULT_ITER,
    DIV_ITER,
    FINISH,
    FINISH_Z
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: arithmetic core of the multiply/divide sequencer.
// Holds the shift registers and performs one radix-2 Booth step (MULT) or one
// restoring-division step on magnitudes (DIV) per i_step. o_hi/o_lo present the
// result the registers would hold after the current step, already sign-fixed for
// DIV, so the sequencer can register it on the final edge.
// Ports:
//   clk, reset_in    clock, synchronous active-high reset
//   i_load           capture op and operands (start accepted in IDLE)
//   i_step           perform one iteration
//   i_op             OP_MULT / OP_DIV
//   i_a, i_b         signed operands (multiplicand/dividend, multiplier/divisor)
//   o_b_zero         i_b is zero (combinational, used at the start edge)
//   o_hi, o_lo       post-step result (product halves or remainder/quotient)
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_b_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // MULT: {r_hi, r_lo, r_q1} is the 2*WIDTH+1 Booth accumulator, r_m the multiplicand.
  // DIV:  r_hi is the partial remainder, r_lo shifts dividend out / quotient in,
  //       r_m the divisor magnitude.
  logic             r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_q1;
  logic [WIDTH-1:0] r_m;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign o_b_zero = (i_b == '0);
  assign w_a_neg  = i_a[WIDTH-1];
  assign w_b_neg  = i_b[WIDTH-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;

  // Booth step: add/subtract on a sign-extended high half so the shifted-in sign
  // bit is correct even when the add overflows WIDTH bits.
  always_comb begin
    w_sum = {r_hi[WIDTH-1], r_hi};
    case ({r_lo[0], r_q1})
      2'b01:   w_sum = {r_hi[WIDTH-1], r_hi} + {r_m[WIDTH-1], r_m};
      2'b10:   w_sum = {r_hi[WIDTH-1], r_hi} - {r_m[WIDTH-1], r_m};
      default: w_sum = {r_hi[WIDTH-1], r_hi};
    endcase
  end

  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

  // Restoring step. The remainder stays below the divisor, so the trial difference
  // always fits WIDTH bits when it is kept.
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_m});
  assign w_sub     = w_shift[WIDTH-1:0] - r_m;
  assign w_div_rem = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign w_div_quo = {r_lo[WIDTH-2:0], w_ge};

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    if (r_op == OP_DIV) begin
      o_hi = r_neg_r ? (~w_div_rem + 1'b1) : w_div_rem;
      o_lo = r_neg_q ? (~w_div_quo + 1'b1) : w_div_quo;
    end else begin
      o_hi = w_mul_hi;
      o_lo = w_mul_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_op    <= OP_MULT;
      r_hi    <= '0;
      r_lo    <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_op <= i_op;
      r_hi <= '0;
      r_q1 <= 1'b0;
      if (i_op == OP_DIV) begin
        r_lo    <= w_a_mag;
        r_m     <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_lo    <= i_b;
        r_m     <= i_a;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end
    end else if (i_step) begin
      if (r_op == OP_DIV) begin
        r_hi <= w_div_rem;
        r_lo <= w_div_quo;
      end else begin
        r_hi <= w_mul_hi;
        r_lo <= w_mul_lo;
        r_q1 <= r_lo[0];
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed MULT/DIV unit for the multicycle datapath.
// The control unit pulses start in IDLE and waits for done; results appear on
// hi_out/lo_out with one-cycle HI/LO write strobes. Divide-by-zero completes one
// cycle after start with done and div_zero and no strobes.
// Optional build macro: MULDIV_ABORT_EN adds the abort input, which cancels an
// iteration in progress without writing results.
// Ports:
//   clk, reset_in        clock, synchronous active-high reset
//   abort                (MULDIV_ABORT_EN only) cancel MULT_ITER/DIV_ITER
//   start, op            request and operation (OP_MULT / OP_DIV)
//   a_in, b_in           signed operands
//   busy, done, div_zero status to the control unit
//   hi_out, lo_out       product halves, or remainder / quotient
//   HI_reg_w, LO_reg_w   HI/LO register write strobes
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_in,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             HI_reg_w,
  output logic             LO_reg_w
);

  localparam int unsigned ITER = WIDTH;
  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_zero, w_zero_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_dz, w_dz_d;
  logic             r_wr, w_wr_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;

  logic             w_load;
  logic             w_step;
  logic             w_abort;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

`ifdef MULDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .reset_in (reset_in),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op     (op),
    .i_a      (a_in),
    .i_b      (b_in),
    .o_b_zero (w_b_zero),
    .o_hi     (w_res_hi),
    .o_lo     (w_res_lo)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_zero_d  = r_zero;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    w_dz_d    = 1'b0;
    w_wr_d    = 1'b0;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_load    = 1'b0;
    w_step    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_cnt_d   = '0;
          w_busy_d  = 1'b1;
          // A zero divisor still spends one cycle in DIV_ITER so that FINISH_Z
          // (and its registered done pulse) lands one edge after the start edge.
          w_zero_d  = (op == OP_DIV) && w_b_zero;
          w_state_d = (op == OP_DIV) ? DIV_ITER : MULT_ITER;
        end
      end
      MULT_ITER, DIV_ITER: begin
        if (w_abort) begin
          w_state_d = IDLE;
          w_zero_d  = 1'b0;
        end else if (r_zero) begin
          w_state_d = FINISH_Z;
          w_zero_d  = 1'b0;
          w_done_d  = 1'b1;
          w_dz_d    = 1'b1;
        end else begin
          w_step  = 1'b1;
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            w_state_d = FINISH;
            w_done_d  = 1'b1;
            w_wr_d    = 1'b1;
            w_hi_d    = w_res_hi;
            w_lo_d    = w_res_lo;
          end else begin
            w_busy_d = 1'b1;
          end
        end
      end
      FINISH, FINISH_Z: w_state_d = IDLE;
      default:          w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_wr    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_zero  <= w_zero_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_dz    <= w_dz_d;
      r_wr    <= w_wr_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign HI_reg_w = r_wr;
  assign LO_reg_w = r_wr;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected results are computed by a
// reference model when an operation is issued, queued, and compared when done rises.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        HI_reg_w;
  logic        LO_reg_w;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .WIDTH (32)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
`ifdef MULDIV_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .HI_reg_w (HI_reg_w),
    .LO_reg_w (LO_reg_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb_;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa   = longint'($signed(a));
    sb_  = longint'($signed(b));
    e.dz = 1'b0;
    e.lat = 32;
    if (o == OP_MULT) begin
      p    = sa * sb_;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.hi  = prev_hi;
      e.lo  = prev_lo;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      q    = sa / sb_;
      r    = sa % sb_;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Starts and ends just after a falling edge. stray>0 pulses a second start that
  // many cycles after the start edge, which must be ignored.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int stray, input string tag);
    exp_t e;
    int   k;
    sb.push_back(model(o, a, b));
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
    check({tag, ":busy_start"}, busy, 1);
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      start = (k == stray);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, ":latency"}, k - 1, e.lat);
    check({tag, ":hi"}, hi_out, e.hi);
    check({tag, ":lo"}, lo_out, e.lo);
    check({tag, ":div_zero"}, div_zero, e.dz);
    check({tag, ":hi_w"}, HI_reg_w, !e.dz);
    check({tag, ":lo_w"}, LO_reg_w, !e.dz);
    check({tag, ":busy_done"}, busy, 0);
    prev_hi = e.hi;
    prev_lo = e.lo;
    // start during the completion cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":done_pulse"}, {done, div_zero, HI_reg_w, LO_reg_w}, 0);
    check({tag, ":hold"}, {hi_out, lo_out}, {prev_hi, prev_lo});
    @(negedge clk);
    check({tag, ":late_start_ignored"}, busy, 0);
  endtask

  initial begin
    int  seen;
    reset_in = 1'b1; start = 1'b0; op = OP_MULT; a_in = '0; b_in = '0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst:status", {busy, done, div_zero, HI_reg_w, LO_reg_w}, 0);
    check("rst:hi", hi_out, 0);
    check("rst:lo", lo_out, 0);
    reset_in = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, "mul_min_sq");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7/-2");
    run_op(OP_DIV, 32'd5, 32'd0, 0, "div_by_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
    run_op(OP_MULT, 32'd3, 32'd5, 5, "mul_stray_start");
    run_op(OP_DIV, 32'd100, 32'd7, 12, "div_stray_start");
    for (int i = 0; i < 6; i++) begin
      run_op(i[0] ? OP_DIV : OP_MULT, $urandom, $urandom, 0, "rnd");
    end

    // Reset in the middle of a MULT, with a stray start at E+5.
    op = OP_MULT; a_in = 32'd9; b_in = 32'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 1; k < 10; k++) begin
      start = (k == 5);
      if (done) seen = 1;
      @(negedge clk);
    end
    start = 1'b0;
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check("midrst:status", {busy, done, div_zero, HI_reg_w, LO_reg_w}, 0);
    check("midrst:result", {hi_out, lo_out}, 0);
    prev_hi = '0;
    prev_lo = '0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check("midrst:no_done", seen, 0);

`ifdef MULDIV_ABORT_EN
    run_op(OP_MULT, 32'd3, 32'd5, 0, "pre_abort");
    op = OP_DIV; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 1; k < 10; k++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort:status", {busy, done, div_zero, HI_reg_w, LO_reg_w}, 0);
    check("abort:result_kept", {hi_out, lo_out}, {prev_hi, prev_lo});
    for (int k = 0; k < 40; k++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check("abort:no_done", seen, 0);
`endif

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
